// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_if
// Description : Time-multiplexed seven-segment scan bus as seen on a display
//               loopback/probe path.
//                 seg_in  [6:0]  segment lines, bit0=a .. bit6=g
//                 dp_in          decimal point of the selected digit
//                 dig_sel [1:0]  one-hot digit select (10=high, 01=low)
//               master : drives the bus (display encoder or bench)
//               slave  : samples the bus (seg_scan_decoder)
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [1:0] dig_sel;

  modport master (output seg_in, output dp_in, output dig_sel);
  modport slave  (input  seg_in, input  dp_in, input  dig_sel);
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Receive side of the two-digit seven-segment compare display.
//               Samples the multiplexed segment bus, decodes each digit back
//               to its hex nibble once it has been stable for STABLE_CNT
//               consecutive samples of that digit, recovers the two compare
//               points and flags points that disagree with the digits.
// Parameters  : STABLE_CNT - identical samples needed to commit (1..2^CNT_W-1)
//               CNT_W      - width of each per-digit stability counter
// Ports       : clk, rst        - clock, synchronous active-high reset
//               bus (slave)     - seg_in / dp_in / dig_sel scan bus
//               din_high/low    - committed nibbles
//               dp_gt / dp_lt   - committed points (high>low / high<low)
//               upd             - pulse: a commit changed the outputs
//               bad_pat         - pulse: undecodable pattern or dig_sel=11
//               cmp_err         - level: points inconsistent with nibbles
// Config      : SEG_ACTIVE_LOW_EN - segment and point lines are active-low
//               (common-anode panel); inverted at entry. dig_sel unaffected.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_decoder_if.slave   bus,
  output logic [3:0]          din_high,
  output logic [3:0]          din_low,
  output logic                dp_gt,
  output logic                dp_lt,
  output logic                upd,
  output logic                bad_pat,
  output logic                cmp_err
);

  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Returns {valid, nibble}; valid=0 for any pattern outside the glyph set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Sample pattern {dp, seg} in lit=1 polarity.
  logic [7:0] pat;
`ifdef SEG_ACTIVE_LOW_EN
  assign pat = ~{bus.dp_in, bus.seg_in};
`else
  assign pat = {bus.dp_in, bus.seg_in};
`endif

  // Index 1 = high digit, index 0 = low digit.
  logic [1:0][7:0]       last_pat, last_nxt;
  logic [1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]            hit, commit;
  logic                  seen_h, seen_l;
  logic [4:0]            dec;
  logic                  dec_ok;
  logic [3:0]            dec_nib;

  assign hit     = {bus.dig_sel == 2'b10, bus.dig_sel == 2'b01};
  assign dec     = decode(pat[6:0]);
  assign dec_ok  = dec[4];
  assign dec_nib = dec[3:0];

  // Run tracking. A commit fires only on the sample that makes the counter
  // reach STABLE_CNT; once saturated the counter holds, so a long steady run
  // commits exactly once. Blank (00) and dig_sel=11 leave both runs intact.
  always_comb begin
    last_nxt = last_pat;
    cnt_nxt  = cnt;
    commit   = 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (hit[d]) begin
        if (pat == last_pat[d]) begin
          if (cnt[d] != STABLE_V) begin
            cnt_nxt[d] = cnt[d] + CNT_ONE;
            commit[d]  = ((cnt[d] + CNT_ONE) == STABLE_V);
          end
        end else begin
          last_nxt[d] = pat;
          cnt_nxt[d]  = CNT_ONE;
          commit[d]   = (STABLE_V == CNT_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pat <= '0;
      cnt      <= '0;
      din_high <= 4'h0;
      din_low  <= 4'h0;
      dp_gt    <= 1'b0;
      dp_lt    <= 1'b0;
      seen_h   <= 1'b0;
      seen_l   <= 1'b0;
      upd      <= 1'b0;
      bad_pat  <= 1'b0;
    end else begin
      last_pat <= last_nxt;
      cnt      <= cnt_nxt;
      upd      <= 1'b0;
      bad_pat  <= (bus.dig_sel == 2'b11) | ((hit != 2'b00) & ~dec_ok);
      // Undecodable patterns still run-track above but never reach outputs.
      if (commit[1] && dec_ok) begin
        din_high <= dec_nib;
        dp_gt    <= pat[7];
        seen_h   <= 1'b1;
        if ({dec_nib, pat[7]} != {din_high, dp_gt}) upd <= 1'b1;
      end
      if (commit[0] && dec_ok) begin
        din_low <= dec_nib;
        dp_lt   <= pat[7];
        seen_l  <= 1'b1;
        if ({dec_nib, pat[7]} != {din_low, dp_lt}) upd <= 1'b1;
      end
    end
  end

  // Straight from registered state so it tracks the outputs with no lag.
  assign cmp_err = seen_h & seen_l &
                   ((dp_gt != (din_high > din_low)) | (dp_lt != (din_high < din_low)));

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder. A behavioural model
//               (glyph table lookup, unbounded run lengths per digit) predicts
//               every output each cycle; directed scenarios pin the model with
//               literal values, then a randomized scan exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int CW     = 4;
  localparam logic [6:0] PATS [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Logical (lit=1) stimulus; translated to panel polarity onto the bus.
  logic [6:0] t_seg = 7'h00;
  logic       t_dp  = 1'b0;
  logic [1:0] t_sel = 2'b00;

  seg_scan_decoder_if bus ();
`ifdef SEG_ACTIVE_LOW_EN
  assign bus.seg_in = ~t_seg;
  assign bus.dp_in  = ~t_dp;
`else
  assign bus.seg_in = t_seg;
  assign bus.dp_in  = t_dp;
`endif
  assign bus.dig_sel = t_sel;

  logic [3:0] din_high, din_low;
  logic       dp_gt, dp_lt, upd, bad_pat, cmp_err;

  seg_scan_decoder #(.STABLE_CNT(STABLE), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .din_high (din_high),
    .din_low  (din_low),
    .dp_gt    (dp_gt),
    .dp_lt    (dp_lt),
    .upd      (upd),
    .bad_pat  (bad_pat),
    .cmp_err  (cmp_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_pat(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (PATS[i] == s) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] m_last [2];
  int         m_run  [2];
  logic [3:0] m_nib  [2];
  logic       m_pt   [2];
  bit         m_seen [2];
  bit         m_upd, m_bad, started;
  int         md, midx;
  logic [7:0] mp;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 8'h00; m_run[i] = 0; m_nib[i] = 4'h0; m_pt[i] = 1'b0; m_seen[i] = 0;
    end
    m_upd = 0; m_bad = 0; started = 0;
  end

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_last[i] = 8'h00; m_run[i] = 0; m_nib[i] = 4'h0; m_pt[i] = 1'b0; m_seen[i] = 0;
      end
      m_upd = 0; m_bad = 0;
    end else begin
      m_upd = 0;
      m_bad = 0;
      if (t_sel == 2'b11) begin
        m_bad = 1;
      end else if (t_sel != 2'b00) begin
        md   = t_sel[1] ? 1 : 0;
        mp   = {t_dp, t_seg};
        midx = find_pat(t_seg);
        if (mp == m_last[md]) m_run[md]++;
        else begin m_last[md] = mp; m_run[md] = 1; end
        if (midx < 0) m_bad = 1;
        else if (m_run[md] == STABLE) begin
          if (m_nib[md] != midx[3:0] || m_pt[md] != t_dp) m_upd = 1;
          m_nib[md]  = midx[3:0];
          m_pt[md]   = t_dp;
          m_seen[md] = 1;
        end
      end
    end
  end

  function automatic logic model_cmp_err();
    if (!(m_seen[0] && m_seen[1])) return 1'b0;
    return (m_pt[1] != (m_nib[1] > m_nib[0])) || (m_pt[0] != (m_nib[1] < m_nib[0]));
  endfunction

  // ---------------- per-cycle compare ----------------
  int upd_cnt = 0;
  int bad_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      check("din_high", {28'b0, din_high}, {28'b0, m_nib[1]});
      check("din_low",  {28'b0, din_low},  {28'b0, m_nib[0]});
      check("dp_gt",    {31'b0, dp_gt},    {31'b0, m_pt[1]});
      check("dp_lt",    {31'b0, dp_lt},    {31'b0, m_pt[0]});
      check("upd",      {31'b0, upd},      {31'b0, m_upd});
      check("bad_pat",  {31'b0, bad_pat},  {31'b0, m_bad});
      check("cmp_err",  {31'b0, cmp_err},  {31'b0, model_cmp_err()});
      if (upd === 1'b1)     upd_cnt++;
      if (bad_pat === 1'b1) bad_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  // Sets the bus, lets one rising edge sample it, returns just after that edge.
  task automatic step(input logic [1:0] sel, input logic [6:0] s, input logic dp);
    t_sel = sel; t_seg = s; t_dp = dp;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(2'b00, 7'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2'b00, 7'h00, 1'b0);
    rst = 1'b0;
  endtask

  int         base_u, base_b;
  logic [7:0] cur [2];
  int         r, dg;

  initial begin
    do_reset();
    check("rst_din_high", {28'b0, din_high}, 32'd0);
    check("rst_din_low",  {28'b0, din_low},  32'd0);
    check("rst_flags", {27'b0, dp_gt, dp_lt, upd, bad_pat, cmp_err}, 32'd0);

    // 1: high=4 with gt point, low=1; both commits change value -> one pulse each
    base_u = upd_cnt;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 7'h66, 1'b1);
      step(2'b01, 7'h06, 1'b0);
    end
    idle();
    check("s1_high", {28'b0, din_high}, 32'd4);
    check("s1_low",  {28'b0, din_low},  32'd1);
    check("s1_pts",  {30'b0, dp_gt, dp_lt}, 32'b10);
    check("s1_cmp",  {31'b0, cmp_err}, 32'd0);
    check("s1_upd_pulses", upd_cnt - base_u, 32'd2);

    // 2: missing gt point -> cmp_err, fixed by a fresh high run
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 7'h66, 1'b0);
      step(2'b01, 7'h06, 1'b0);
    end
    check("s2_cmp_set", {31'b0, cmp_err}, 32'd1);
    for (int i = 0; i < 4; i++) step(2'b10, 7'h66, 1'b1);
    check("s2_cmp_clr", {31'b0, cmp_err}, 32'd0);
    check("s2_gt", {31'b0, dp_gt}, 32'd1);

    // 3: broken run does not commit; cmp_err reveals the high commit of 0
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b01, 7'h06, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b10, 7'h3F, 1'b0);
    step(2'b10, 7'h06, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b10, 7'h3F, 1'b0);
    check("s3_no_commit", {31'b0, cmp_err}, 32'd0);
    step(2'b10, 7'h3F, 1'b0);
    check("s3_commit", {31'b0, cmp_err}, 32'd1);
    check("s3_high", {28'b0, din_high}, 32'd0);

    // 4: undecodable samples and dig_sel=11
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b10, 7'h5B, 1'b0);
    base_b = bad_cnt;
    for (int i = 0; i < 6; i++) step(2'b10, 7'h00, 1'b0);
    idle();
    check("s4_bad_pulses", bad_cnt - base_b, 32'd6);
    check("s4_high_kept", {28'b0, din_high}, 32'd2);
    base_b = bad_cnt;
    for (int i = 0; i < 3; i++) step(2'b10, 7'h4F, 1'b0);
    step(2'b11, 7'h3F, 1'b0);
    step(2'b10, 7'h4F, 1'b0);
    idle();
    check("s4_sel11_bad", bad_cnt - base_b, 32'd1);
    check("s4_run_kept", {28'b0, din_high}, 32'd3);

    // 5: equal digits, repeated identical commit gives no upd
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b10, 7'h79, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b01, 7'h79, 1'b0);
    check("s5_digits", {24'b0, din_high, din_low}, 32'hEE);
    check("s5_cmp", {31'b0, cmp_err}, 32'd0);
    idle();
    base_u = upd_cnt;
    step(2'b10, 7'h06, 1'b0);
    for (int i = 0; i < 7; i++) step(2'b10, 7'h79, 1'b0);
    idle();
    check("s5_no_upd", upd_cnt - base_u, 32'd0);

    // 6: reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b10, 7'h6D, 1'b0);
    check("s6_pre", {28'b0, din_high}, 32'd5);
    for (int i = 0; i < 2; i++) step(2'b10, 7'h7F, 1'b0);
    do_reset();
    check("s6_cleared", {28'b0, din_high}, 32'd0);
    for (int i = 0; i < 3; i++) step(2'b10, 7'h7F, 1'b0);
    check("s6_partial", {28'b0, din_high}, 32'd0);
    step(2'b10, 7'h7F, 1'b0);
    check("s6_commit", {28'b0, din_high}, 32'd8);

    // Randomized scan: held per-digit patterns that change now and then,
    // occasional blanks, illegal selects, garbage patterns and resets.
    cur[0] = {1'b0, PATS[1]};
    cur[1] = {1'b1, PATS[4]};
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if (r == 0) begin
        step(2'b00, 7'(PATS[$urandom_range(0, 15)]), 1'b0);
      end else if (r == 1) begin
        step(2'b11, cur[1][6:0], cur[1][7]);
      end else begin
        dg = r % 2;
        if ($urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 7) == 0) cur[dg] = 8'($urandom_range(0, 255));
          else cur[dg] = {1'($urandom_range(0, 1)), PATS[$urandom_range(0, 15)]};
        end
        step(dg == 1 ? 2'b10 : 2'b01, cur[dg][6:0], cur[dg][7]);
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
